// File: rtl/hud_text_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hud_pkg : shared definitions for the HUD text controller.
//   - glyph codes used when composing the HUD line
//   - HUD_MAX_HEARTS : heart cells available on the line
//   - hud_state_e    : controller states
//   - glyph_t        : one line-buffer element (7-bit font code)
//   - line_t         : the full 16-character committed line
// ---------------------------------------------------------------------------
package hud_pkg;

  typedef logic [6:0] glyph_t;

  localparam glyph_t GLYPH_SPACE  = 7'h00;
  localparam glyph_t GLYPH_HEART  = 7'h03;
  localparam glyph_t GLYPH_S      = 7'h53;
  localparam glyph_t GLYPH_C      = 7'h43;
  localparam glyph_t GLYPH_COLON  = 7'h3A;
  localparam glyph_t GLYPH_DIGIT0 = 7'h30;

  localparam int HUD_MAX_HEARTS = 8;
  localparam int HUD_CHARS      = 16;

  typedef logic [HUD_CHARS-1:0][6:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } hud_state_e;

endpackage

// File: rtl/hud_text_ctrl_if.sv
// ---------------------------------------------------------------------------
// hud_text_ctrl_if : game-state / pixel-pipeline side bus of the HUD text
// controller.
//   master : game logic + pixel pipeline (drives frame_start, health, score,
//            DrawX, DrawY; receives busy, is_drawn, addr, offset)
//   slave  : hud_text_ctrl
// ---------------------------------------------------------------------------
interface hud_text_ctrl_if;
  logic        frame_start;
  logic [3:0]  health;
  logic [15:0] score;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        busy;
  logic        is_drawn;
  logic [10:0] addr;
  logic [2:0]  offset;

  modport master (
    output frame_start, health, score, DrawX, DrawY,
    input  busy, is_drawn, addr, offset
  );

  modport slave (
    input  frame_start, health, score, DrawX, DrawY,
    output busy, is_drawn, addr, offset
  );
endinterface

// File: rtl/hud_text_ctrl_bcd_converter.sv
// ---------------------------------------------------------------------------
// bcd_converter : sequential double-dabble, 16-bit binary to 5 BCD digits,
// one iteration per clock.
// Ports:
//   Clk, Reset_n : clock, synchronous active-low reset
//   start        : load bin and begin 16 iterations
//   bin[15:0]    : value to convert (sampled with start)
//   last         : high during the 16th (final) iteration cycle
//   done         : single-cycle pulse, the cycle after last; digits valid
//   digits[19:0] : BCD result, most significant digit in [19:16]
// ---------------------------------------------------------------------------
module bcd_converter
  import hud_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        last,
  output logic        done,
  output logic [19:0] digits
);

  // [35:16] BCD nibbles, [15:0] binary bits still to be shifted in
  logic [35:0] dd_p0;
  logic [4:0]  cnt;
  logic        run;

  function automatic logic [35:0] dd_step(input logic [35:0] v);
    logic [35:0] a;
    a = v;
    for (int i = 0; i < 5; i++) begin
      if (a[16+4*i +: 4] >= 4'd5)
        a[16+4*i +: 4] = a[16+4*i +: 4] + 4'd3;
    end
    return {a[34:0], 1'b0};
  endfunction

  assign last   = run && (cnt == 5'd15);
  assign digits = dd_p0[35:16];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dd_p0 <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (start) begin
        dd_p0 <= {20'd0, bin};
        cnt   <= '0;
        run   <= 1'b1;
      end else if (run) begin
        dd_p0 <= dd_step(dd_p0);
        cnt   <= cnt + 5'd1;
        if (cnt == 5'd15)
          run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hud_text_ctrl.sv
// ---------------------------------------------------------------------------
// hud_text_ctrl : HUD text controller.
// Once per frame it snapshots health/score, converts the score to decimal
// (bcd_converter, 16 cycles) and commits a 16-character line in one cycle.
// Every cycle it maps DrawX/DrawY to a font-ROM row address for the HUD
// strip, always reading the committed line so no half-built text shows.
// Ports:
//   Clk, Reset_n : clock, synchronous active-low reset
//   bus (slave)  : frame_start, health, score, DrawX, DrawY in;
//                  busy, is_drawn, addr, offset out (lookup outputs have
//                  1-cycle latency from DrawX/DrawY)
// Parameters: ROW_Y0 (first HUD scanline), NUM_CHARS (chars per line).
// Build option: define HUD_LEADING_BLANK_EN to blank leading zero digits
// of the score (the last digit is always shown).
// ---------------------------------------------------------------------------
module hud_text_ctrl
  import hud_pkg::*;
#(
  parameter int ROW_Y0    = 8,
  parameter int NUM_CHARS = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  hud_text_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] CONVERT = ST_CONVERT;
  localparam logic [1:0] COMMIT  = ST_COMMIT;

  localparam logic [10:0] Y_LO = 11'(ROW_Y0);
  localparam logic [10:0] Y_HI = 11'(ROW_Y0 + 16);
  localparam logic [10:0] X_HI = 11'(8 * NUM_CHARS);

  logic [1:0]  state;
  logic [3:0]  hp_snap;
  line_t       line_buf;

  logic        conv_start;
  logic        conv_last;
  logic        conv_done;
  logic [19:0] conv_digits;

  // Compose the full line from the health snapshot and BCD score.
  function automatic line_t build_line(input logic [3:0] hp, input logic [19:0] bcd);
    line_t      l;
    logic [3:0] hearts;
    logic [3:0] nib;
`ifdef HUD_LEADING_BLANK_EN
    logic       lead;
    lead = 1'b1;
`endif
    hearts = (hp > 4'(HUD_MAX_HEARTS)) ? 4'(HUD_MAX_HEARTS) : hp;
    for (int i = 0; i < HUD_MAX_HEARTS; i++)
      l[i] = (4'(i) < hearts) ? GLYPH_HEART : GLYPH_SPACE;
    l[8]  = GLYPH_S;
    l[9]  = GLYPH_C;
    l[10] = GLYPH_COLON;
    for (int d = 0; d < 5; d++) begin
      nib     = bcd[19-4*d -: 4];
      l[11+d] = GLYPH_DIGIT0 + {3'b000, nib};
`ifdef HUD_LEADING_BLANK_EN
      // only the first four digits may blank, so zero still reads "0"
      if (d < 4) begin
        lead = lead && (nib == 4'd0);
        if (lead)
          l[11+d] = GLYPH_SPACE;
      end
`endif
    end
    return l;
  endfunction

  // frame_start is honoured only in IDLE; the converter's binary half is
  // the score snapshot.
  assign conv_start = (state == IDLE) && bus.frame_start;
  assign bus.busy   = (state != IDLE);

  bcd_converter u_bcd (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (conv_start),
    .bin     (bus.score),
    .last    (conv_last),
    .done    (conv_done),
    .digits  (conv_digits)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      hp_snap  <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            hp_snap <= bus.health;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_last)
            state <= COMMIT;
        end
        COMMIT: begin
          if (conv_done)
            line_buf <= build_line(hp_snap, conv_digits);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- lookup stage p0: region decode and glyph fetch ----
  logic       in_region_p0;
  logic [3:0] char_idx_p0;
  logic [3:0] row_p0;
  glyph_t     code_p0;

  assign in_region_p0 = ({1'b0, bus.DrawY} >= Y_LO) && ({1'b0, bus.DrawY} < Y_HI) &&
                        ({1'b0, bus.DrawX} < X_HI);
  assign char_idx_p0  = bus.DrawX[6:3];
  assign row_p0       = 4'(bus.DrawY - 10'(ROW_Y0));
  assign code_p0      = line_buf[char_idx_p0];

  // ---- lookup stage p1: registered font-ROM request ----
  logic        is_drawn_p1;
  logic [10:0] addr_p1;
  logic [2:0]  offset_p1;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      is_drawn_p1 <= 1'b0;
      addr_p1     <= '0;
      offset_p1   <= '0;
    end else if (in_region_p0) begin
      is_drawn_p1 <= 1'b1;
      addr_p1     <= {code_p0, 4'b0000} + {7'b0, row_p0};
      offset_p1   <= 3'd7 - bus.DrawX[2:0];
    end else begin
      is_drawn_p1 <= 1'b0;
      addr_p1     <= '0;
      offset_p1   <= '0;
    end
  end

  assign bus.is_drawn = is_drawn_p1;
  assign bus.addr     = addr_p1;
  assign bus.offset   = offset_p1;

endmodule

// File: doc/hud_text_ctrl.md
# hud_text_ctrl

HUD text controller: once per frame it snapshots player health and score, converts the score to decimal over several cycles, and commits a 16-character line buffer. It then serves per-pixel glyph lookups (font-ROM row address, bit offset, draw flag) to the colour mapper for the HUD strip at the top of the screen. It sits between game-state logic and the font ROM and replaces static HUD text with live values.

## Interface
Parameters:
- ROW_Y0, 8: first HUD scanline; the strip spans 16 lines.
- NUM_CHARS, 16: characters per HUD line, each 8 px wide.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset_n  in  1  reset; synchronous, active-low.
- frame_start  in  1  single-cycle pulse at start of vertical blank.
- health  in  4  player health, 0..15.
- score  in  16  player score, unsigned.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- busy  out  1  update in progress.
- is_drawn  out  1  a glyph cell covers the pixel.
- addr  out  11  font-ROM row index.
- offset  out  3  font-ROM bit column.

## Operation
- States are IDLE, CONVERT and COMMIT.
- IDLE -> CONVERT on frame_start:
  - latch health and score into snapshot registers;
  - load the double-dabble register with 20 BCD bits = 0 and 16 binary bits = the score snapshot;
  - set the iteration counter to 0.
- CONVERT: one iteration per cycle.
  - Add 3 to every BCD nibble that is >= 5, then shift the whole register left 1.
  - After 16 iterations go to COMMIT.
- COMMIT: one cycle.
  - Write the line buffer atomically, then return to IDLE.
  - Chars 0..7: heart (0x03) for index < min(health, 8); otherwise space (0x00). Health above 8 clamps to 8.
  - Chars 8..10: 'S' 0x53, 'C' 0x43, ':' 0x3A.
  - Chars 11..15: the five BCD digits, most significant first, each encoded as 0x30 + digit.
- busy = 1 in CONVERT and COMMIT.
- frame_start while busy is ignored, with no restart and no re-latch.
- The lookup path runs every cycle, independent of the FSM, and always reads the committed buffer, so no partial update is ever visible.
  - In region when ROW_Y0 <= DrawY < ROW_Y0+16 and DrawX < 8*NUM_CHARS.
  - Char index is DrawX[6:3], code = buffer[index] (7 bits).
  - In region: addr = (DrawY - ROW_Y0) + 16*code; offset = 7 - DrawX[2:0]; is_drawn = 1. This includes space cells.
  - Outside the region: addr = 0, offset = 0, is_drawn = 0.
- Width rule: 16*127 + 15 = 2047 fits in 11 bits; no truncation.

## Timing
- Reset state: IDLE, busy = 0, is_drawn = 0, addr = 0, offset = 0.
- Reset clears the snapshots, the BCD register and the counter, and fills the line buffer with 0x00.
- Lookup outputs are registered: 1-cycle latency from DrawX/DrawY. The pixel pipeline delays its colour select by 1 cycle to match.
- Update latency, with frame_start sampled in cycle 0:
  - CONVERT occupies cycles 1..16, COMMIT is cycle 17;
  - the new buffer is visible to lookups from cycle 18, so outputs reflect it from cycle 19;
  - busy is high for cycles 1..17.
- Reset_n low mid-update aborts immediately. The buffer returns to all spaces; no partial commit occurs.
- Each latch completes in IDLE, so back-to-back frame_start pulses 18 cycles apart are all honoured.

## Configuration
- HUD_LEADING_BLANK_EN defined: at COMMIT, leading zero digits in chars 11..14 become 0x00. Char 15 is always a digit, so score 0 shows "    0".
- HUD_LEADING_BLANK_EN undefined: all five digits are shown, e.g. "00042".

## Structure
- Package hud_pkg holds:
  - glyph constants GLYPH_SPACE, GLYPH_HEART, GLYPH_S, GLYPH_C, GLYPH_COLON, GLYPH_DIGIT0;
  - HUD_MAX_HEARTS = 8;
  - the state enum;
  - the line-buffer element typedef (7-bit glyph code).
- Sub-module bcd_converter holds the double-dabble register and counter.
  - Handshake: start pulse in; done pulse plus digits[19:0] out.
  - Done is asserted in the cycle the controller enters COMMIT.

## Test plan
- Reset, then DrawX=0, DrawY=8 -> next cycle is_drawn=1, addr=0, offset=7. DrawY=30 -> is_drawn=0, addr=0.
- health=3, score=65535, frame_start -> busy is high exactly 17 cycles. Chars 0..2 then return code 0x03, chars 3..7 return 0x00, and chars 11..15 return 0x36,0x35,0x35,0x33,0x35. Check at DrawX=88, DrawY=12: addr=4+16*0x36=868, offset=7.
- health=12, score=42 -> 8 hearts. Digits "00042" without the macro; "   42" (0x00 x3, 0x34, 0x32) with HUD_LEADING_BLANK_EN.
- Second frame_start 5 cycles into an update -> ignored; busy still drops after 17 cycles total, and the first snapshot is displayed.
- Reset_n low at CONVERT cycle 10 -> next cycle busy=0 and the buffer is all 0x00. A lookup of char 11 at DrawY=8 gives addr=0, is_drawn=1.
